// File: rtl/rvv_backend_rs_mpmp_fifo_pkg.sv
// Shared defaults for the reservation-station multi-push/multi-pop buffer.
// Holds the dispatch width and per-unit RS sizing used by the top and pointer blocks.
package rvv_backend_rs_mpmp_fifo_pkg;

    localparam int NUM_DP_UOP = 2;
    localparam int RS_DWIDTH  = 64;
    localparam int RS_DEPTH   = 8;
    localparam int RS_NUM_POP = 2;

endpackage

// File: rtl/rvv_backend_mp_ptr.sv
// Wrapping pointer with prefix-length increment, shared by write and read sides.
// Ports: clk, rst_n, flush, fire (prefix mask), ptr (with wrap bit), idx[k] = (ptr+k) mod DEPTH.
module rvv_backend_mp_ptr
    import rvv_backend_rs_mpmp_fifo_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int N     = NUM_DP_UOP,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [N-1:0]         fire,
    output logic [PW-1:0]        ptr,
    output logic [N-1:0][AW-1:0] idx
);

    logic [PW-1:0] len;

    // fire is a prefix, so the highest set slot gives its length
    always_comb begin
        len = '0;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) len = PW'(i + 1);
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_idx
        assign idx[k] = ptr[AW-1:0] + AW'(k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ptr <= '0;
        else if (flush) ptr <= '0;
        else            ptr <= ptr + len;
    end

endmodule

// File: rtl/rvv_backend_rs_mpmp_fifo.sv
// Reservation-station buffer: up to NUM_PUSH uops in and NUM_POP uops out per cycle.
// Ports: push_valid/push_data/push_ready in, pop_valid/pop_data/pop_ready out,
// flush clears all entries, fifo_empty/fifo_full/count report occupancy.
module rvv_backend_rs_mpmp_fifo
    import rvv_backend_rs_mpmp_fifo_pkg::*;
#(
    parameter int DWIDTH   = RS_DWIDTH,
    parameter int DEPTH    = RS_DEPTH,
    parameter int NUM_PUSH = NUM_DP_UOP,
    parameter int NUM_POP  = RS_NUM_POP,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [NUM_PUSH-1:0]              push_valid,
    input  logic [NUM_PUSH-1:0][DWIDTH-1:0]  push_data,
    output logic [NUM_PUSH-1:0]              push_ready,
    output logic [NUM_POP-1:0]               pop_valid,
    output logic [NUM_POP-1:0][DWIDTH-1:0]   pop_data,
    input  logic [NUM_POP-1:0]               pop_ready,
    output logic                             fifo_empty,
    output logic                             fifo_full,
    output logic [CW-1:0]                    count
);

    logic [DWIDTH-1:0]               mem [DEPTH];
    logic [CW-1:0]                   wr_ptr;
    logic [CW-1:0]                   rd_ptr;
    logic [NUM_PUSH-1:0][AW-1:0]     wr_idx;
    logic [NUM_POP-1:0][AW-1:0]      rd_idx;
    logic [NUM_PUSH-1:0]             push_fire;
    logic [NUM_POP-1:0]              pop_fire;
    logic [CW-1:0]                   space;

    // wrap bit makes the difference exact for both empty and full
    assign count      = wr_ptr - rd_ptr;
    assign space      = CW'(DEPTH) - count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));

    // ready/valid come from registered pointers only, never from the inputs
    for (genvar i = 0; i < NUM_PUSH; i++) begin : g_push
        assign push_ready[i] = space > CW'(i);
    end

    for (genvar j = 0; j < NUM_POP; j++) begin : g_pop
        assign pop_valid[j] = count > CW'(j);
        assign pop_data[j]  = mem[rd_idx[j]];
    end

    assign push_fire = push_valid & push_ready;
    assign pop_fire  = pop_valid & pop_ready;

    rvv_backend_mp_ptr #(.DEPTH(DEPTH), .N(NUM_PUSH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .fire  (push_fire),
        .ptr   (wr_ptr),
        .idx   (wr_idx)
    );

    rvv_backend_mp_ptr #(.DEPTH(DEPTH), .N(NUM_POP)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .fire  (pop_fire),
        .ptr   (rd_ptr),
        .idx   (rd_idx)
    );

    // storage is left unreset; entries are only meaningful below count
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PUSH; i++) begin
            if (push_fire[i]) mem[wr_idx[i]] <= push_data[i];
        end
    end

    // a prefix mask m satisfies m & (m+1) == 0
    a_push_prefix : assert property (@(posedge clk) disable iff (!rst_n)
        (push_valid & (push_valid + NUM_PUSH'(1))) == '0);

    a_pop_prefix : assert property (@(posedge clk) disable iff (!rst_n)
        (pop_ready & (pop_ready + NUM_POP'(1))) == '0);

endmodule

// File: tb/tb_rvv_backend_rs_mpmp_fifo.sv
// Bench for the reservation-station multi-push/multi-pop buffer.
// Directed vector table, async-reset sequence and randomized traffic against a queue model.
module tb_rvv_backend_rs_mpmp_fifo;

    localparam int D = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       push_valid = '0;
    logic [1:0][63:0] push_data = '0;
    logic [1:0]       push_ready;
    logic [1:0]       pop_valid;
    logic [1:0][63:0] pop_data;
    logic [1:0]       pop_ready = '0;
    logic             fifo_empty;
    logic             fifo_full;
    logic [3:0]       count;

    rvv_backend_rs_mpmp_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .count      (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [63:0] q[$];
    int          tag = 0;
    int          next_pop_tag = 0;
    int          popped = 0;

    typedef struct {
        logic [1:0] pv;
        logic [1:0] pr;
        logic       fl;
        int         cnt;
        logic [1:0] prdy;
        logic [1:0] pval;
        logic       emp;
        logic       ful;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int plen(input logic [1:0] m);
        return m[0] ? (m[1] ? 2 : 1) : 0;
    endfunction

    function automatic logic [1:0] pmask(input int k);
        return (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
    endfunction

    // drive inputs after the falling edge and compare against the model
    task automatic apply(input logic [1:0] pv, input logic [1:0] pr,
                         input logic fl);
        int n;
        @(negedge clk);
        push_valid   = pv;
        pop_ready    = pr;
        flush        = fl;
        push_data[0] = {$urandom, 32'(tag)};
        push_data[1] = {$urandom, 32'(tag + 1)};
        #1;
        n = q.size();
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(fifo_empty), 64'(n == 0));
        chk("full", 64'(fifo_full), 64'(n == D));
        for (int i = 0; i < 2; i++) begin
            chk("push_ready", 64'(push_ready[i]), 64'((D - n) > i));
            chk("pop_valid", 64'(pop_valid[i]), 64'(n > i));
            if (n > i) chk("pop_data", pop_data[i], q[i]);
        end
    endtask

    // advance the model across the rising edge
    task automatic commit();
        int n, p, qn;
        logic [63:0] d0, d1;
        n  = q.size();
        p  = plen(push_valid);
        if (p > D - n) p = D - n;
        qn = plen(pop_ready);
        if (qn > n) qn = n;
        d0 = push_data[0];
        d1 = push_data[1];
        for (int j = 0; j < qn; j++) begin
            chk("order", 64'(pop_data[j][31:0]), 64'(32'(next_pop_tag)));
            next_pop_tag++;
        end
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            for (int j = 0; j < qn; j++) void'(q.pop_front());
            if (p > 0) q.push_back(d0);
            if (p > 1) q.push_back(d1);
            popped += qn;
        end
        tag += p;
        if (flush) next_pop_tag = tag;
    endtask

    vec_t vt[16];

    initial begin
        vt[0]  = '{2'b11, 2'b00, 1'b0, 0, 2'b11, 2'b00, 1'b1, 1'b0};
        vt[1]  = '{2'b11, 2'b00, 1'b0, 2, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[2]  = '{2'b11, 2'b00, 1'b0, 4, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[3]  = '{2'b11, 2'b00, 1'b0, 6, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[4]  = '{2'b11, 2'b11, 1'b0, 8, 2'b00, 2'b11, 1'b0, 1'b1};
        vt[5]  = '{2'b11, 2'b11, 1'b0, 6, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[6]  = '{2'b00, 2'b01, 1'b0, 6, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[7]  = '{2'b11, 2'b11, 1'b1, 5, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[8]  = '{2'b00, 2'b00, 1'b0, 0, 2'b11, 2'b00, 1'b1, 1'b0};
        vt[9]  = '{2'b11, 2'b00, 1'b0, 0, 2'b11, 2'b00, 1'b1, 1'b0};
        vt[10] = '{2'b11, 2'b00, 1'b0, 2, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[11] = '{2'b11, 2'b00, 1'b0, 4, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[12] = '{2'b01, 2'b00, 1'b0, 6, 2'b11, 2'b11, 1'b0, 1'b0};
        vt[13] = '{2'b00, 2'b00, 1'b0, 7, 2'b01, 2'b11, 1'b0, 1'b0};
        vt[14] = '{2'b11, 2'b00, 1'b0, 7, 2'b01, 2'b11, 1'b0, 1'b0};
        vt[15] = '{2'b00, 2'b00, 1'b0, 8, 2'b00, 2'b11, 1'b0, 1'b1};

        // reset state
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_push_ready", 64'(push_ready), 64'd3);
        chk("rst_pop_valid", 64'(pop_valid), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        for (int r = 0; r < 16; r++) begin
            apply(vt[r].pv, vt[r].pr, vt[r].fl);
            chk($sformatf("tbl%0d_count", r), 64'(count), 64'(vt[r].cnt));
            chk($sformatf("tbl%0d_push_ready", r), 64'(push_ready),
                64'(vt[r].prdy));
            chk($sformatf("tbl%0d_pop_valid", r), 64'(pop_valid),
                64'(vt[r].pval));
            chk($sformatf("tbl%0d_empty", r), 64'(fifo_empty), 64'(vt[r].emp));
            chk($sformatf("tbl%0d_full", r), 64'(fifo_full), 64'(vt[r].ful));
            commit();
        end

        // async reset between edges with three entries held
        apply(2'b00, 2'b00, 1'b1); commit();
        apply(2'b11, 2'b00, 1'b0); commit();
        apply(2'b01, 2'b00, 1'b0); commit();
        @(negedge clk);
        push_valid = '0;
        pop_ready  = '0;
        flush      = 1'b0;
        chk("pre_arst_count", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_push_ready", 64'(push_ready), 64'd3);
        chk("arst_pop_valid", 64'(pop_valid), 64'd0);
        chk("arst_empty", 64'(fifo_empty), 64'd1);
        chk("arst_full", 64'(fifo_full), 64'd0);
        q.delete();
        next_pop_tag = tag;
        popped = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // ordered stream of at least 20 uops, no flush
        for (int c = 0; c < 400 && popped < 20; c++) begin
            apply(pmask($urandom_range(0, 2)), pmask($urandom_range(0, 2)), 1'b0);
            commit();
        end
        checks++;
        if (popped >= 20) passes++;
        else $display("FAIL stream_timeout: popped %0d required 20", popped);

        // randomized traffic with occasional flush
        for (int c = 0; c < 400; c++) begin
            apply(pmask($urandom_range(0, 2)), pmask($urandom_range(0, 2)),
                  ($urandom_range(0, 39) == 0));
            commit();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
